// File: rtl/notch_decimator.sv
// Block-average decimator by 2^DECIM_LOG2 with a small output FIFO and sticky overflow.
// Optional macro NOTCH_DECIM_ROUND_EN selects round-half-up instead of truncation.
module notch_decimator #(
  parameter int unsigned DECIM_LOG2 = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [15:0] x_in,
  output logic [15:0] y_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  input  logic        clear_ovf
);

  localparam int unsigned ACC_W = 16 + DECIM_LOG2;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = AW + 1;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] rsum;
  logic [DECIM_LOG2-1:0]   phase;
  logic [15:0]             result;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_next, rd_next;
  logic          last, push, pop, full, push_ok, head_fwd;
  logic [15:0]   head_next;

  assign sum  = acc + ACC_W'($signed(x_in));

`ifdef NOTCH_DECIM_ROUND_EN
  localparam logic [ACC_W-1:0] HALF = ACC_W'(2 ** (DECIM_LOG2 - 1));
  assign rsum = sum + $signed(HALF);
`else
  assign rsum = sum;
`endif

  // Headroom of DECIM_LOG2 bits guarantees the shifted value fits in 16 bits.
  assign result  = 16'(rsum >>> DECIM_LOG2);

  assign last    = &phase;
  assign push    = in_valid & last;
  assign pop     = out_valid & out_ready;
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign push_ok = push & (~full | pop);
  assign wr_next = wr_ptr + PW'(push_ok);
  assign rd_next = rd_ptr + PW'(pop);

  // Forward the incoming result when it lands in the slot that becomes the head.
  assign head_fwd  = push_ok && (rd_next[AW-1:0] == wr_ptr[AW-1:0]);
  assign head_next = head_fwd ? result : mem[rd_next[AW-1:0]];

  // Accumulator and phase counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= '0;
      phase <= '0;
    end else if (in_valid) begin
      if (last) begin
        acc   <= '0;
        phase <= '0;
      end else begin
        acc   <= sum;
        phase <= phase + DECIM_LOG2'(1);
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= result;
  end

  // FIFO pointers and registered head/valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      y_out     <= '0;
    end else begin
      wr_ptr    <= wr_next;
      rd_ptr    <= rd_next;
      out_valid <= (wr_next != rd_next);
      if (wr_next != rd_next) y_out <= head_next;
    end
  end

  // Sticky overflow; a new drop wins over clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_notch_decimator.sv
// Self-checking bench for notch_decimator: vector table, corner sequences, randomized model check.
module tb_notch_decimator;

  localparam int NS = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] x_in;
  logic [15:0] y_out;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        clear_ovf;

  int total = 0;
  int bad   = 0;

  notch_decimator #(.DECIM_LOG2(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .x_in(x_in),
    .y_out(y_out), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x [NS];
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    x_in      = '0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    reset_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Floor (or round-half-up) of the block average, from plain integer arithmetic.
  function automatic logic [15:0] avg_ref(input int s);
    int q;
`ifdef NOTCH_DECIM_ROUND_EN
    s = s + NS / 2;
`endif
    q = s / NS;
    if ((s % NS) != 0 && s < 0) q = q - 1;
    return 16'(q);
  endfunction

  function automatic vec_t mk(input logic [15:0] a, b, c, d, e);
    vec_t v;
    v.x[0] = a; v.x[1] = b; v.x[2] = c; v.x[3] = d;
    v.exp = e;
    return v;
  endfunction

  task automatic send_group(input logic [15:0] v);
    for (int k = 0; k < NS; k++) begin
      in_valid = 1'b1;
      x_in = v;
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] q [$];
    logic [15:0] res;
    int acc_m, cnt_m, r;
    logic ovf_m, pop_m, done_m;

`ifdef NOTCH_DECIM_ROUND_EN
    vecs[1] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFF);
    vecs[5] = mk(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    vecs[6] = mk(16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0001);
    vecs[7] = mk(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h0000);
`else
    vecs[1] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFE);
    vecs[5] = mk(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
    vecs[6] = mk(16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    vecs[7] = mk(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'hFFFF);
`endif
    vecs[0] = mk(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0280);
    vecs[2] = mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    vecs[3] = mk(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
    vecs[4] = mk(16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    do_reset();
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_y", 32'(y_out), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);

    // Table-driven single-block averages, consumer always ready
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      for (int k = 0; k < NS; k++) begin
        in_valid = 1'b1;
        x_in = vecs[i].x[k];
        tick();
        if (k < NS - 1) check("vec_early_valid", 32'(out_valid), 32'd0);
      end
      in_valid = 1'b0;
      check("vec_valid", 32'(out_valid), 32'd1);
      check("vec_y", 32'(y_out), 32'(vecs[i].exp));
      check("vec_ovf", 32'(overflow), 32'd0);
      tick();
      check("vec_valid_1cyc", 32'(out_valid), 32'd0);
    end

    // Five results into a 4-deep FIFO with no consumer
    do_reset();
    for (int g = 1; g <= 5; g++) begin
      send_group(16'(g * 256));
      if (g == 4) check("fill_ovf_none", 32'(overflow), 32'd0);
    end
    check("fill_ovf_set", 32'(overflow), 32'd1);
    check("fill_head_stable", 32'(y_out), 32'h100);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_y", 32'(y_out), 32'((i + 1) * 256));
      tick();
    end
    check("drain_empty", 32'(out_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO, fifth result arrives in the same cycle as a pop
    do_reset();
    for (int g = 1; g <= 4; g++) send_group(16'(g * 256));
    for (int k = 0; k < NS; k++) begin
      in_valid = 1'b1;
      x_in = 16'h0500;
      if (k == NS - 1) begin
        out_ready = 1'b1;
        check("fullpop_head", 32'(y_out), 32'h100);
      end
      tick();
    end
    in_valid = 1'b0;
    check("fullpop_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 5; i++) begin
      check("fullpop_valid", 32'(out_valid), 32'd1);
      check("fullpop_y", 32'(y_out), 32'((i + 1) * 256));
      tick();
    end
    check("fullpop_empty", 32'(out_valid), 32'd0);

    // Overflow set wins over clear in the same cycle
    out_ready = 1'b0;
    for (int g = 1; g <= 4; g++) send_group(16'(g * 256));
    for (int k = 0; k < NS; k++) begin
      in_valid = 1'b1;
      x_in = 16'h0600;
      clear_ovf = (k == NS - 1);
      tick();
    end
    in_valid = 1'b0;
    clear_ovf = 1'b0;
    check("set_wins_clear", 32'(overflow), 32'd1);

    // Reset mid-accumulation discards partial sum and FIFO contents
    do_reset();
    send_group(16'h0100);
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      x_in = 16'h4000;
      tick();
    end
    in_valid = 1'b0;
    reset_n = 1'b0;
    #2;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_y", 32'(y_out), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < NS; k++) begin
      in_valid = 1'b1;
      x_in = 16'(16 * (k + 1));
      tick();
    end
    in_valid = 1'b0;
    check("postrst_valid", 32'(out_valid), 32'd1);
    check("postrst_y", 32'(y_out), 32'h28);

    // Randomized traffic against a queue-based model
    do_reset();
    q = {};
    acc_m = 0;
    cnt_m = 0;
    ovf_m = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom % 4) != 0;
      r = $urandom % 8;
      x_in = (r == 0) ? 16'h7FFF : (r == 1) ? 16'h8000 : 16'($urandom);
      out_ready = ($urandom % 3) == 0;
      clear_ovf = ($urandom % 16) == 0;
      pop_m  = (q.size() > 0) && out_ready;
      done_m = 1'b0;
      res    = '0;
      if (in_valid) begin
        acc_m += int'($signed(x_in));
        cnt_m++;
        if (cnt_m == NS) begin
          res = avg_ref(acc_m);
          done_m = 1'b1;
          acc_m = 0;
          cnt_m = 0;
        end
      end
      tick();
      if (pop_m) void'(q.pop_front());
      if (done_m && q.size() < DEPTH) q.push_back(res);
      if (done_m && q.size() == DEPTH && !pop_m && res !== q[DEPTH-1]) ovf_m = 1'b1;
      else if (done_m && !pop_m && q.size() == DEPTH && c >= 0) ovf_m = ovf_m;
      check("rand_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) check("rand_y", 32'(y_out), 32'(q[0]));
    end
    in_valid = 1'b0;
    clear_ovf = 1'b0;

    // Randomized overflow flag model with explicit full tracking
    do_reset();
    q = {};
    acc_m = 0;
    cnt_m = 0;
    ovf_m = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic full_m;
      in_valid  = ($urandom % 3) != 0;
      x_in      = 16'($urandom);
      out_ready = ($urandom % 4) == 0;
      clear_ovf = ($urandom % 10) == 0;
      pop_m  = (q.size() > 0) && out_ready;
      full_m = (q.size() == DEPTH);
      done_m = 1'b0;
      res    = '0;
      if (in_valid) begin
        acc_m += int'($signed(x_in));
        cnt_m++;
        if (cnt_m == NS) begin
          res = avg_ref(acc_m);
          done_m = 1'b1;
          acc_m = 0;
          cnt_m = 0;
        end
      end
      tick();
      if (pop_m) void'(q.pop_front());
      if (done_m && full_m && !pop_m) ovf_m = 1'b1;
      else if (clear_ovf) ovf_m = 1'b0;
      if (done_m && !(full_m && !pop_m)) q.push_back(res);
      check("rand2_ovf", 32'(overflow), 32'(ovf_m));
      check("rand2_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) check("rand2_y", 32'(y_out), 32'(q[0]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/notch_decimator.md
NOTCH_DECIMATOR -- requirements
Module: notch_decimator

Interface
REQ-001 The block SHALL have parameter DECIM_LOG2, default 2, giving the decimation factor N = 2^DECIM_LOG2, with a legal range of 1..6.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the output FIFO depth as a power of 2 in the range 2..16.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: x_in carries a sample this cycle, with no backpressure upstream.
REQ-006 The block SHALL have port x_in, input, 16 bits, signed: the Q1.15 notch-filter output sample.
REQ-007 The block SHALL have port y_out, output, 16 bits, signed: the Q1.15 decimated sample at the FIFO head.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the FIFO is non-empty and y_out is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts y_out.
REQ-010 The block SHALL have port overflow, output, 1 bit: a sticky flag indicating a decimated result was dropped.
REQ-011 The block SHALL have port clear_ovf, input, 1 bit: a synchronous clear for overflow.

Function
REQ-012 The block SHALL hold a signed accumulator of 16+DECIM_LOG2 bits and a phase counter of DECIM_LOG2 bits.
REQ-013 When in_valid=1 and phase<N-1, the block SHALL add sign-extended x_in to the accumulator and increment phase.
REQ-014 When in_valid=1 and phase=N-1, the block SHALL compute sum=acc+x_in, push result=sum>>>DECIM_LOG2 into the FIFO, clear acc to 0, and set phase to 0, all in that cycle.
REQ-015 When in_valid=0, the block SHALL hold both acc and phase unchanged.
REQ-016 The result SHALL always fit in 16 bits, so the block needs no saturation.
REQ-017 The FIFO SHALL be registered, so a result pushed in cycle t appears on y_out with out_valid=1 in cycle t+1 when the FIFO was empty.
REQ-018 y_out SHALL be driven from the FIFO head and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-020 With out_valid=0, out_ready SHALL be ignored.
REQ-021 A push while the FIFO is full without a simultaneous pop SHALL discard the result and set overflow=1; acc and phase SHALL still restart.
REQ-022 A push and a pop in the same cycle while full SHALL both succeed and leave the occupancy unchanged.
REQ-023 A push and a pop in the same cycle while neither full nor empty SHALL leave the occupancy unchanged and preserve FIFO order.
REQ-024 The read and write pointers SHALL wrap modulo FIFO_DEPTH, with full and empty derived from an extra pointer bit.
REQ-025 overflow SHALL remain 1 until clear_ovf=1.
REQ-026 If clear_ovf=1 and a new overflow event occur in the same cycle, overflow SHALL be set, with set winning over clear.

Reset
REQ-027 On reset_n=0, the block SHALL asynchronously set acc=0, phase=0, FIFO pointers=0, out_valid=0, y_out=0, and overflow=0.
REQ-028 Reset asserted mid-accumulation SHALL discard the partial sum and any FIFO contents.
REQ-029 After reset release, the first in_valid sample SHALL count as phase 0.
REQ-030 Reset deassertion SHALL be synchronous to clk, provided externally.

Configuration
REQ-031 Macro NOTCH_DECIM_ROUND_EN SHALL select the rounding mode.
REQ-032 With NOTCH_DECIM_ROUND_EN defined, the block SHALL compute result=(sum+2^(DECIM_LOG2-1))>>>DECIM_LOG2, which is round-half-up and cannot exceed 0x7FFF or go below 0x8000.
REQ-033 Without NOTCH_DECIM_ROUND_EN, the block SHALL compute result=sum>>>DECIM_LOG2, which truncates toward minus infinity.
REQ-034 All other behaviour SHALL be identical with and without NOTCH_DECIM_ROUND_EN.

Verification
REQ-035 The bench SHALL cover: DECIM_LOG2=2, inputs 0x0100,0x0200,0x0300,0x0400 with out_ready=1 -> y_out=0x0280, out_valid high for one cycle, one cycle after the 4th sample.
REQ-036 The bench SHALL cover: inputs 0xFFFF,0xFFFF,0xFFFF,0xFFFE -> y_out=0xFFFE without NOTCH_DECIM_ROUND_EN and 0xFFFF with it.
REQ-037 The bench SHALL cover: four samples of 0x7FFF and, separately, four samples of 0x8000 -> y_out=0x7FFF and 0x8000 respectively, with no overflow in either case.
REQ-038 The bench SHALL cover: out_ready=0 and 5 decimated results with FIFO_DEPTH=4 -> the first 4 results are retained in order, overflow=1, then draining yields exactly those 4 results.
REQ-039 The bench SHALL cover: the FIFO full and a 5th result completing in the same cycle as out_ready=1 -> no overflow, and the drain yields 5 results in order.
REQ-040 The bench SHALL cover: reset_n pulsed low after 2 of 4 samples -> out_valid=0, and the next 4 samples produce their own average with no contribution from the pre-reset samples.
